// File: rtl/trc_pkg.sv
// Shared types for the traffic-light phase sequencer.
// Phase encoding, lamp codes and the phase-order helper.
package trc_pkg;

  typedef enum logic [2:0] {
    PH_RED   = 3'd0,
    PH_RY    = 3'd1,
    PH_GRN   = 3'd2,
    PH_YEL   = 3'd3,
    PH_FLASH = 3'd4
  } phase_e;

  // Lamp code bit order is {r, y, g}
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_RY  = 3'b110;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;

  function automatic phase_e next_phase(input phase_e p);
    unique case (p)
      PH_RED:  next_phase = PH_RY;
      PH_RY:   next_phase = PH_GRN;
      PH_GRN:  next_phase = PH_YEL;
      default: next_phase = PH_RED;
    endcase
  endfunction

  function automatic logic [2:0] lamp_code(input phase_e p);
    unique case (p)
      PH_RED:  lamp_code = LAMP_RED;
      PH_RY:   lamp_code = LAMP_RY;
      PH_GRN:  lamp_code = LAMP_GRN;
      PH_YEL:  lamp_code = LAMP_YEL;
      default: lamp_code = LAMP_OFF;
    endcase
  endfunction

endpackage

// File: rtl/trc_phase_ctrl_load_rev_cnt.sv
// Loadable up/down counter used as the phase timer.
// Load has priority over counting; rev=1 counts down.
module load_rev_cnt #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         rev,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= rev ? q - 1'b1 : q + 1'b1;
    end
  end

endmodule

// File: rtl/trc_phase_ctrl.sv
// Traffic-light phase sequencer for one approach.
// Drives a down-counting phase timer; handles ped, hold and night flash.
module trc_phase_ctrl
  import trc_pkg::*;
#(
  parameter int N      = 4,
  parameter int T_RED  = 10,
  parameter int T_RY   = 2,
  parameter int T_GRN  = 12,
  parameter int T_YEL  = 3,
  parameter int T_GMIN = 4
) (
  input  logic         clk,
  input  logic         R,
  input  logic         tick,
  input  logic         hold,
  input  logic         night,
  input  logic         ped_req,
  output logic         lamp_r,
  output logic         lamp_y,
  output logic         lamp_g,
  output logic [2:0]   phase,
  output logic [N-1:0] remain,
  output logic         ped_ack
);

  localparam int TMAX = 2 ** N;

  if (T_RED < 1 || T_RED > TMAX) begin : g_bad_red
    $error("T_RED out of range");
  end
  if (T_RY < 1 || T_RY > TMAX) begin : g_bad_ry
    $error("T_RY out of range");
  end
  if (T_GRN < 1 || T_GRN > TMAX) begin : g_bad_grn
    $error("T_GRN out of range");
  end
  if (T_YEL < 1 || T_YEL > TMAX) begin : g_bad_yel
    $error("T_YEL out of range");
  end
  if (T_GMIN < 1 || T_GMIN > T_GRN) begin : g_bad_gmin
    $error("T_GMIN out of range");
  end

  localparam logic [N-1:0] D_RED  = N'(T_RED - 1);
  localparam logic [N-1:0] D_RY   = N'(T_RY - 1);
  localparam logic [N-1:0] D_GRN  = N'(T_GRN - 1);
  localparam logic [N-1:0] D_YEL  = N'(T_YEL - 1);
  localparam logic [N-1:0] D_GMIN = N'(T_GMIN - 1);

  phase_e       ph_q;
  phase_e       ph_nxt;
  logic [2:0]   lamp_q;
  logic         init_ld;
  logic         shortd;
  logic         ld;
  logic [N-1:0] ld_d;
  logic         en;
  logic         shorten;
  logic         live;
  logic         zero;

  assign live = tick & ~hold;
  assign zero = (remain == '0);

  always_comb begin
    ph_nxt  = ph_q;
    ld      = 1'b0;
    ld_d    = '0;
    shorten = 1'b0;
    if (init_ld) begin
      ld     = 1'b1;
      ld_d   = D_RED;
      ph_nxt = PH_RED;
    end else if (night && ph_q != PH_FLASH) begin
      ld     = 1'b1;
      ph_nxt = PH_FLASH;
    end else if (!night && ph_q == PH_FLASH) begin
      ld     = 1'b1;
      ld_d   = D_RED;
      ph_nxt = PH_RED;
    end else if (live && zero && ph_q != PH_FLASH) begin
      ld     = 1'b1;
      ph_nxt = next_phase(ph_q);
      unique case (ph_nxt)
        PH_RY:   ld_d = D_RY;
        PH_GRN:  ld_d = D_GRN;
        PH_YEL:  ld_d = D_YEL;
        default: ld_d = D_RED;
      endcase
    end else if (live && ph_q == PH_GRN && ped_ack
                 && !shortd && remain > D_GMIN) begin
      ld      = 1'b1;
      ld_d    = D_GMIN;
      shorten = 1'b1;
    end
  end

  // Masking on zero keeps the timer from wrapping in FLASH or stalls
  assign en = live & ~ld & ~zero;

  load_rev_cnt #(.N(N)) u_tmr (
    .clk   (clk),
    .rst_n (~R),
    .load  (ld),
    .rev   (1'b1),
    .en    (en),
    .d     (ld_d),
    .q     (remain)
  );

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      ph_q    <= PH_RED;
      lamp_q  <= LAMP_RED;
      ped_ack <= 1'b0;
      init_ld <= 1'b1;
      shortd  <= 1'b0;
    end else begin
      init_ld <= 1'b0;
      ph_q    <= ph_nxt;
      if (ph_nxt != PH_FLASH) begin
        lamp_q <= lamp_code(ph_nxt);
      end else if (ph_q != PH_FLASH) begin
        lamp_q <= LAMP_OFF;
      end else if (live) begin
        lamp_q <= {1'b0, ~lamp_q[1], 1'b0};
      end
      if (ld && ph_q == PH_YEL && ph_nxt == PH_RED) begin
        ped_ack <= 1'b0;
      end else if (ped_req) begin
        ped_ack <= 1'b1;
      end
      if (ph_nxt != PH_GRN) begin
        shortd <= 1'b0;
      end else if (shorten) begin
        shortd <= 1'b1;
      end
    end
  end

  assign phase  = ph_q;
  assign lamp_r = lamp_q[2];
  assign lamp_y = lamp_q[1];
  assign lamp_g = lamp_q[0];

endmodule

// File: tb/tb_trc_phase_ctrl.sv
// Directed bench for trc_phase_ctrl.
// Tick every 4 clk; checks sampled 1 time unit after the rising edge.
module tb_trc_phase_ctrl;

  logic       clk = 1'b0;
  logic       R = 1'b1;
  logic       tick = 1'b0;
  logic       hold = 1'b0;
  logic       night = 1'b0;
  logic       ped_req = 1'b0;
  logic       lamp_r;
  logic       lamp_y;
  logic       lamp_g;
  logic [2:0] phase;
  logic [3:0] remain;
  logic       ped_ack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trc_phase_ctrl dut (
    .clk     (clk),
    .R       (R),
    .tick    (tick),
    .hold    (hold),
    .night   (night),
    .ped_req (ped_req),
    .lamp_r  (lamp_r),
    .lamp_y  (lamp_y),
    .lamp_g  (lamp_g),
    .phase   (phase),
    .remain  (remain),
    .ped_ack (ped_ack)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int ph, input int rem,
                        input int lmp);
    chk({tag, "_phase"}, int'(phase), ph);
    chk({tag, "_remain"}, int'(remain), rem);
    chk({tag, "_lamps"}, int'({lamp_r, lamp_y, lamp_g}), lmp);
  endtask

  task automatic step(input logic t);
    @(negedge clk);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic tk(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0);
      step(1'b0);
      step(1'b0);
      step(1'b1);
    end
  endtask

  initial begin
    #12;
    chk_st("reset", 0, 0, 3'b100);
    chk("reset_ack", int'(ped_ack), 0);

    // tick on the first edge after release is ignored by init load
    @(negedge clk);
    R = 1'b0;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    chk_st("init", 0, 9, 3'b100);

    tk(4);
    chk("red_cnt", int'(remain), 5);
    hold = 1'b1;
    tk(20);
    chk_st("hold", 0, 5, 3'b100);
    hold = 1'b0;
    tk(1);
    chk("hold_rel", int'(remain), 4);
    tk(5);
    chk_st("ry", 1, 1, 3'b110);
    tk(2);
    chk_st("grn", 2, 11, 3'b001);

    tk(1);
    @(negedge clk);
    ped_req = 1'b1;
    @(posedge clk);
    #1;
    ped_req = 1'b0;
    chk("ped_ack1", int'(ped_ack), 1);
    chk("ped_nochg", int'(remain), 10);
    tk(1);
    chk_st("shorten", 2, 3, 3'b001);
    tk(3);
    chk("short_g0", int'(phase), 2);
    tk(1);
    chk_st("yel", 3, 2, 3'b010);
    chk("ack_yel", int'(ped_ack), 1);
    tk(3);
    chk_st("red2", 0, 9, 3'b100);
    chk("ack_clr", int'(ped_ack), 0);

    tk(12);
    tk(9);
    chk("grn_late", int'(remain), 2);
    @(negedge clk);
    ped_req = 1'b1;
    @(posedge clk);
    #1;
    ped_req = 1'b0;
    chk("ped_ack2", int'(ped_ack), 1);
    tk(1);
    chk_st("noshort", 2, 1, 3'b001);
    tk(2);
    chk_st("yel2", 3, 2, 3'b010);
    chk("ack_yel2", int'(ped_ack), 1);
    tk(3);
    chk("ack_clr2", int'(ped_ack), 0);
    chk("red3", int'(phase), 0);

    tk(12);
    tk(1);
    chk("pre_night", int'(remain), 10);
    night = 1'b1;
    step(1'b0);
    chk_st("flash", 4, 0, 3'b000);
    tk(1);
    chk_st("flash_y1", 4, 0, 3'b010);
    tk(1);
    chk_st("flash_y0", 4, 0, 3'b000);
    night = 1'b0;
    step(1'b0);
    chk_st("day", 0, 9, 3'b100);

    tk(24);
    chk_st("yel3", 3, 2, 3'b010);
    #3;
    R = 1'b1;
    #1;
    chk_st("async_rst", 0, 0, 3'b100);
    chk("rst_ack", int'(ped_ack), 0);
    @(negedge clk);
    R = 1'b0;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    chk_st("reinit", 0, 9, 3'b100);
    tk(1);
    chk("reinit_cnt", int'(remain), 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
